// File: rtl/dict_proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dict_proc_pkg
//  Description : Shared types for the sensing-matrix (dictionary) processor:
//                solver command encoding, data bus width and the signed
//                fixed-point word type.
//  Revision    : 1.0 - initial release
// ============================================================================
package dict_proc_pkg;

    localparam int FP_DATA_BUS_WIDTH = 32;

    typedef logic signed [FP_DATA_BUS_WIDTH-1:0] fp_32_t;

    typedef enum logic [1:0] {
        CMD_COMPUTE_INNER_PRODUCTS = 2'd0,
        CMD_LOAD_SENSING_MATRIX    = 2'd1,
        CMD_LOAD_ATOM_SCALE_FACTOR = 2'd2,
        CMD_RESERVED               = 2'd3
    } command_e;

endpackage : dict_proc_pkg
`default_nettype wire

// File: rtl/dict_processor_modport_fp_mac.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mac
//  Description : Signed Q-format multiply-accumulate. Each enabled cycle adds
//                (coef * sample) >>> Q, truncated to 32 bits, to the
//                accumulator; the sum wraps modulo 2^32.
//  Ports       : clock, reset_n (sync, active-low)
//                i_clear  - synchronous accumulator clear (wins over i_en)
//                i_en     - accumulate this cycle
//                i_coef   - matrix coefficient
//                i_sample - residual sample
//                o_acc    - accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mac
    import dict_proc_pkg::*;
#(
    parameter int Q = 15
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   i_clear,
    input  logic   i_en,
    input  fp_32_t i_coef,
    input  fp_32_t i_sample,
    output fp_32_t o_acc
);

    logic signed [63:0] w_prod;
    fp_32_t             w_term;
    fp_32_t             r_acc;

    // Full-precision signed product, arithmetic shift, then keep the low word.
    assign w_prod = 64'(i_coef) * 64'(i_sample);
    assign w_term = fp_32_t'(w_prod >>> Q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_term;
        end
    end

    assign o_acc = r_acc;

endmodule : fp_mac
`default_nettype wire

// File: rtl/dict_processor_modport.sv
`default_nettype none
// ============================================================================
//  Module      : dict_processor_modport
//  Description : Dictionary processor. Loads a ROWS x COLUMNS matrix
//                column-major, computes inner products of every column with a
//                residual read from external RAM (BATCH_SIZE MACs at a time),
//                writes products to external RAM, and latches atom index and
//                scale factor.
//  Ports       : clock, reset_n (sync, active-low)
//                start/command/done        - controller handshake
//                read_addr/read_data       - residual/matrix/atom input path
//                write_enable/addr/data    - product RAM write port
//                batch_products_transferred- pulse with last write of a batch
//                atom_index/atom_scale_factor - latched atom parameters
//  Revision    : 1.0 - initial release
// ============================================================================
module dict_processor_modport
    import dict_proc_pkg::*;
#(
    parameter int ROWS       = 64,
    parameter int COLUMNS    = 256,
    parameter int BATCH_SIZE = 64,
    parameter int Q          = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  command,
    output logic        done,
    output logic [7:0]  read_addr,
    input  logic [31:0] read_data,
    output logic        write_enable,
    output logic [7:0]  write_addr,
    output logic [31:0] write_data,
    output logic        batch_products_transferred,
    output logic [31:0] atom_index,
    output logic [31:0] atom_scale_factor
);

    localparam int BATCHES = COLUMNS / BATCH_SIZE;
    localparam int WORDS   = ROWS * COLUMNS;
    localparam int LOAD_W  = (WORDS > 1)      ? $clog2(WORDS)      : 1;
    localparam int ROW_W   = (ROWS > 1)       ? $clog2(ROWS)       : 1;
    localparam int WIDX_W  = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int BATCH_W = (BATCHES > 1)    ? $clog2(BATCHES)    : 1;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LOAD_MATRIX = 3'd1;
    localparam logic [2:0] S_RES_DELAY   = 3'd2;
    localparam logic [2:0] S_COMPUTE     = 3'd3;
    localparam logic [2:0] S_WRITE       = 3'd4;
    localparam logic [2:0] S_LASF_INDEX  = 3'd5;
    localparam logic [2:0] S_LASF_SCALE  = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [LOAD_W-1:0]  r_load_cnt;
    logic [ROW_W-1:0]   r_row;
    logic [WIDX_W-1:0]  r_widx;
    logic [BATCH_W-1:0] r_batch;
    logic               r_done;
    logic               w_done_next;
    logic [31:0]        r_atom_index;
    logic [31:0]        r_atom_scale;
    fp_32_t             r_phi [WORDS];   // column-major: index = c*ROWS + r
    fp_32_t             w_acc [BATCH_SIZE];
    logic               w_mac_clear;
    logic               w_mac_en;
    logic               w_load_last;
    logic               w_row_last;
    logic               w_widx_last;
    logic               w_batch_last;

    assign w_load_last  = (r_load_cnt == LOAD_W'(WORDS - 1));
    assign w_row_last   = (r_row == ROW_W'(ROWS - 1));
    assign w_widx_last  = (r_widx == WIDX_W'(BATCH_SIZE - 1));
    assign w_batch_last = (r_batch == BATCH_W'(BATCHES - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next state ----------------
    // done is registered, so it is raised on the transition that ends an
    // operation and appears the following cycle.
    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (command_e'(command))
                        CMD_LOAD_SENSING_MATRIX:    w_next_state = S_LOAD_MATRIX;
                        CMD_COMPUTE_INNER_PRODUCTS: w_next_state = S_RES_DELAY;
                        CMD_LOAD_ATOM_SCALE_FACTOR: w_next_state = S_LASF_INDEX;
                        default:                    w_next_state = S_IDLE;
                    endcase
                end
            end
            S_LOAD_MATRIX: begin
                if (w_load_last) begin
                    w_next_state = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            S_RES_DELAY: w_next_state = S_COMPUTE;
            S_COMPUTE: begin
                if (w_row_last) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                if (w_widx_last) begin
                    if (w_batch_last) begin
                        w_next_state = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_next_state = S_RES_DELAY;
                    end
                end
            end
            S_LASF_INDEX: begin
                w_next_state = S_LASF_SCALE;
                w_done_next  = 1'b1;
            end
            S_LASF_SCALE: w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        read_addr                  = '0;
        write_enable               = 1'b0;
        write_addr                 = '0;
        write_data                 = '0;
        batch_products_transferred = 1'b0;
        w_mac_clear                = 1'b0;
        w_mac_en                   = 1'b0;
        case (r_state)
            S_RES_DELAY: w_mac_clear = 1'b1;
            S_COMPUTE: begin
                // Request the next row while the current row's data arrives.
                read_addr = 8'(int'(r_row) + 1);
                w_mac_en  = 1'b1;
            end
            S_WRITE: begin
                write_enable               = 1'b1;
                write_addr                 = 8'(int'(r_batch) * BATCH_SIZE + int'(r_widx));
                write_data                 = w_acc[r_widx];
                batch_products_transferred = w_widx_last;
            end
            default: ;
        endcase
    end

    // ---------------- counters and latched registers ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_load_cnt   <= '0;
            r_row        <= '0;
            r_widx       <= '0;
            r_batch      <= '0;
            r_done       <= 1'b0;
            r_atom_index <= '0;
            r_atom_scale <= '0;
        end else begin
            r_done <= w_done_next;
            case (r_state)
                S_IDLE: begin
                    r_load_cnt <= '0;
                    r_batch    <= '0;
                end
                S_LOAD_MATRIX: r_load_cnt <= r_load_cnt + LOAD_W'(1);
                S_RES_DELAY: begin
                    r_row  <= '0;
                    r_widx <= '0;
                end
                S_COMPUTE: r_row <= r_row + ROW_W'(1);
                S_WRITE: begin
                    r_widx <= r_widx + WIDX_W'(1);
                    if (w_widx_last) r_batch <= r_batch + BATCH_W'(1);
                end
                S_LASF_INDEX: r_atom_index <= read_data;
                S_LASF_SCALE: r_atom_scale <= read_data;
                default: ;
            endcase
        end
    end

    // Matrix storage survives reset.
    always_ff @(posedge clock) begin
        if (r_state == S_LOAD_MATRIX) begin
            r_phi[r_load_cnt] <= fp_32_t'(read_data);
        end
    end

    // ---------------- MAC array ----------------
    for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_mac
        logic [LOAD_W-1:0] w_phi_idx;
        assign w_phi_idx = LOAD_W'((int'(r_batch) * BATCH_SIZE + gi) * ROWS + int'(r_row));

        fp_mac #(
            .Q (Q)
        ) u_mac (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_clear  (w_mac_clear),
            .i_en     (w_mac_en),
            .i_coef   (r_phi[w_phi_idx]),
            .i_sample (fp_32_t'(read_data)),
            .o_acc    (w_acc[gi])
        );
    end

    assign done              = r_done;
    assign atom_index        = r_atom_index;
    assign atom_scale_factor = r_atom_scale;

endmodule : dict_processor_modport
`default_nettype wire

// File: tb/tb_dict_processor_modport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dict_processor_modport
//  Description : Self-checking bench for dict_processor_modport (ROWS=4,
//                COLUMNS=8, BATCH_SIZE=4, Q=15). Residual RAM is modelled
//                with one cycle of read latency; product writes are collected
//                by a monitor and compared with expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dict_processor_modport;

    localparam int ROWS = 4, COLUMNS = 8, BATCH_SIZE = 4, Q = 15;
    localparam int WORDS = ROWS * COLUMNS;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  command = 2'd0;
    logic        done;
    logic [7:0]  read_addr;
    logic [31:0] read_data;
    logic        write_enable;
    logic [7:0]  write_addr;
    logic [31:0] write_data;
    logic        bpt;
    logic [31:0] atom_index;
    logic [31:0] atom_scale_factor;

    logic        use_ram = 1'b0;
    logic [31:0] drv_data = '0;
    logic [31:0] ram_q = '0;
    logic [31:0] res_ram [256];
    logic [31:0] phi_m [ROWS][COLUMNS];

    int n_err = 0;
    int n_chk = 0;

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_bpt_q[$];
    int done_cnt = 0;

    typedef struct packed {
        logic [3:0][31:0] res;
        logic [7:0][31:0] exp;
    } vec_t;
    vec_t tbl [2];

    dict_processor_modport #(
        .ROWS(ROWS), .COLUMNS(COLUMNS), .BATCH_SIZE(BATCH_SIZE), .Q(Q)
    ) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .start                      (start),
        .command                    (command),
        .done                       (done),
        .read_addr                  (read_addr),
        .read_data                  (read_data),
        .write_enable               (write_enable),
        .write_addr                 (write_addr),
        .write_data                 (write_data),
        .batch_products_transferred (bpt),
        .atom_index                 (atom_index),
        .atom_scale_factor          (atom_scale_factor)
    );

    always #5 clock = ~clock;

    assign read_data = use_ram ? ram_q : drv_data;
    always @(posedge clock) ram_q <= res_ram[read_addr];

    always @(negedge clock) begin
        if (write_enable) begin
            wr_addr_q.push_back(int'(write_addr));
            wr_data_q.push_back(int'(write_data));
            wr_bpt_q.push_back(int'(bpt));
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Inner product of column c with the residual, straight from the Q-format rule.
    function automatic logic [31:0] model_ip(input int c);
        int acc;
        longint p;
        acc = 0;
        for (int r = 0; r < ROWS; r++) begin
            p = longint'($signed(phi_m[r][c])) * longint'($signed(res_ram[r]));
            acc += int'(p >>> Q);
        end
        return acc;
    endfunction

    task automatic do_load(input string tag);
        int done_at;
        int dcount;
        logic [31:0] stream[$];
        done_at = -1;
        dcount  = 0;
        for (int c = 0; c < COLUMNS; c++)
            for (int r = 0; r < ROWS; r++)
                stream.push_back(phi_m[r][c]);
        use_ram = 1'b0;
        start   = 1'b1;
        command = 2'd1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < WORDS + 4; k++) begin
            if (k < WORDS) drv_data = stream[k];
            @(posedge clock); #1;
            if (done) begin
                dcount++;
                if (done_at < 0) done_at = k + 2;
            end
        end
        chk({tag, " done latency"}, done_at, WORDS + 1);
        chk({tag, " done pulses"}, dcount, 1);
    endtask

    task automatic do_compute(input string tag, input bit disturb, input logic [7:0][31:0] exp);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_bpt_q.delete();
        done_cnt = 0;
        use_ram  = 1'b1;
        start    = 1'b1;
        command  = 2'd0;
        @(posedge clock); #1;
        start = 1'b0;
        while (!seen && cyc < 200) begin
            if (disturb) begin
                if (cyc == 3) begin
                    start   = 1'b1;
                    command = 2'd1;
                end else if (cyc == 6) begin
                    start = 1'b0;
                end
            end
            @(posedge clock); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        @(posedge clock); #1;
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: got no done, want done within 200 cycles", tag);
        end
        chk({tag, " write count"}, wr_addr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wr_addr_q[i], i);
            chk($sformatf("%s data[%0d]", tag, i), wr_data_q[i], exp[i]);
            chk($sformatf("%s bpt[%0d]", tag, i), wr_bpt_q[i], ((i % BATCH_SIZE) == BATCH_SIZE - 1) ? 1 : 0);
        end
        chk({tag, " done pulses"}, done_cnt, 1);
    endtask

    initial begin
        logic [7:0][31:0] rexp;

        for (int i = 0; i < 256; i++) res_ram[i] = '0;

        // Directed vectors on the diagonal-repeat matrix.
        tbl[0].res = {32'd131072, 32'd98304, 32'd65536, 32'd32768};
        tbl[0].exp = {32'd131072, 32'd98304, 32'd65536, 32'd32768,
                      32'd131072, 32'd98304, 32'd65536, 32'd32768};
        tbl[1].res = {32'd0, 32'd0, 32'd0, 32'hFFFF8000};
        tbl[1].exp = {32'd0, 32'd0, 32'd0, 32'hFFFF8000,
                      32'd0, 32'd0, 32'd0, 32'hFFFF8000};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst done", {31'd0, done}, 0);
        chk("rst read_addr", {24'd0, read_addr}, 0);
        chk("rst write_enable", {31'd0, write_enable}, 0);
        chk("rst write_addr", {24'd0, write_addr}, 0);
        chk("rst write_data", write_data, 0);
        chk("rst bpt", {31'd0, bpt}, 0);
        chk("rst atom_index", atom_index, 0);
        chk("rst atom_scale", atom_scale_factor, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++)
                phi_m[r][c] = (r == (c % ROWS)) ? 32'd32768 : 32'd0;
        do_load("load diag");

        for (int v = 0; v < 2; v++) begin
            for (int r = 0; r < ROWS; r++) res_ram[r] = tbl[v].res[r];
            do_compute($sformatf("vec%0d", v), 1'b0, tbl[v].exp);
        end

        // Atom load.
        use_ram = 1'b0;
        done_cnt = 0;
        start   = 1'b1;
        command = 2'd2;
        @(posedge clock); #1;
        start    = 1'b0;
        drv_data = 32'd5;
        chk("atom done early", {31'd0, done}, 0);
        @(posedge clock); #1;
        drv_data = 32'h0000_4000;
        chk("atom done", {31'd0, done}, 1);
        @(posedge clock); #1;
        chk("atom index", atom_index, 32'd5);
        chk("atom scale", atom_scale_factor, 32'h0000_4000);
        chk("atom done pulses", done_cnt, 1);

        // Reset during COMPUTE.
        for (int r = 0; r < ROWS; r++) res_ram[r] = tbl[0].res[r];
        use_ram  = 1'b1;
        done_cnt = 0;
        start    = 1'b1;
        command  = 2'd0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("abort done", {31'd0, done}, 0);
        chk("abort read_addr", {24'd0, read_addr}, 0);
        chk("abort write_enable", {31'd0, write_enable}, 0);
        chk("abort write_data", write_data, 0);
        chk("abort bpt", {31'd0, bpt}, 0);
        chk("abort atom_index", atom_index, 0);
        chk("abort atom_scale", atom_scale_factor, 0);
        reset_n = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        chk("abort no done", done_cnt, 0);
        do_compute("after abort", 1'b0, tbl[0].exp);

        // Reserved command does nothing.
        wr_addr_q.delete();
        done_cnt = 0;
        start    = 1'b1;
        command  = 2'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) begin @(posedge clock); #1; end
        chk("cmd3 done", done_cnt, 0);
        chk("cmd3 writes", wr_addr_q.size(), 0);
        chk("cmd3 read_addr", {24'd0, read_addr}, 0);

        // Start during COMPUTE must be ignored.
        do_compute("busy start", 1'b1, tbl[0].exp);

        // Random matrix and residuals against the reference model.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++)
                phi_m[r][c] = ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 131072) - 65536;
        do_load("load rand");
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < ROWS; r++)
                res_ram[r] = (t == 0) ? $urandom_range(0, 262144) - 131072 : $urandom();
            for (int c = 0; c < COLUMNS; c++) rexp[c] = model_ip(c);
            do_compute($sformatf("rand%0d", t), 1'b0, rexp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule : tb_dict_processor_modport
`default_nettype wire
